// File: rtl/clk_rst_pkg.sv
// Shared types and default constants for the MMCM reset sequencer.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    MRST    = 3'd0,
    WAIT    = 3'd1,
    STABLE  = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4
  } seq_state_t;

  localparam int DEF_NUM_STAGES         = 3;
  localparam int DEF_MMCM_RST_CYCLES    = 16;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_STAGE_GAP          = 16;
  localparam int DEF_LOCK_TIMEOUT       = 65536;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer for a level signal crossing into clk.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;
  logic meta_d;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clk_rst_sequencer.sv
// Pulses MMCM reset, qualifies lock, then releases stage resets in order.
// Any lock loss after release or a software request restarts from MRST.
module clk_rst_sequencer
  import clk_rst_pkg::*;
#(
  parameter int NUM_STAGES         = DEF_NUM_STAGES,
  parameter int MMCM_RST_CYCLES    = DEF_MMCM_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int STAGE_GAP          = DEF_STAGE_GAP,
  parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT
) (
  input  logic                  clk12,
  input  logic                  rst,
  input  logic                  locked_async,
  input  logic                  sw_reset_req,
  output logic                  mmcm_rst,
  output logic [NUM_STAGES-1:0] rst_stage,
  output logic                  ready,
  output logic [7:0]            lock_loss_count,
  output logic [7:0]            timeout_count
);

  localparam int MAX_PARAM = max_of(max_of(MMCM_RST_CYCLES, LOCK_STABLE_CYCLES),
                                    max_of(STAGE_GAP, LOCK_TIMEOUT));
  localparam int CNT_W = (MAX_PARAM > 1) ? $clog2(MAX_PARAM) : 1;
  localparam int IDX_W = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] MRST_LAST    = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_ALL      = IDX_W'(NUM_STAGES);

  logic                  lock_s;
  seq_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            lock_loss_q, lock_loss_d;
  logic [7:0]            timeout_q, timeout_d;
  logic                  mmcm_rst_q, mmcm_rst_d;
  logic [NUM_STAGES-1:0] rst_stage_q, rst_stage_d;
  logic                  ready_q, ready_d;
  logic                  lock_abort;
  logic                  sw_abort;

  sync_2ff u_lock_sync (
    .clk (clk12),
    .rst (rst),
    .d   (locked_async),
    .q   (lock_s)
  );

  always_ff @(posedge clk12) begin
    if (rst) begin
      state_q     <= MRST;
      cnt_q       <= '0;
      idx_q       <= '0;
      lock_loss_q <= 8'd0;
      timeout_q   <= 8'd0;
      mmcm_rst_q  <= 1'b1;
      rst_stage_q <= '1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lock_loss_q <= lock_loss_d;
      timeout_q   <= timeout_d;
      mmcm_rst_q  <= mmcm_rst_d;
      rst_stage_q <= rst_stage_d;
      ready_q     <= ready_d;
    end
  end

  // Lock loss is checked before the software request so a coincident pair is counted.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    lock_loss_d = lock_loss_q;
    timeout_d   = timeout_q;
    lock_abort  = ((state_q == RELEASE) || (state_q == RUN)) && !lock_s;
    sw_abort    = sw_reset_req && (state_q != MRST);

    if (lock_abort) begin
      state_d = MRST;
      cnt_d   = '0;
      idx_d   = '0;
      if (lock_loss_q != 8'hFF) lock_loss_d = lock_loss_q + 8'd1;
    end else if (sw_abort) begin
      state_d = MRST;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        MRST: begin
          if (cnt_q == MRST_LAST) begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
        WAIT: begin
          if (lock_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = MRST;
            cnt_d   = '0;
            if (timeout_q != 8'hFF) timeout_d = timeout_q + 8'd1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RELEASE;
            cnt_d   = '0;
            idx_d   = IDX_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_ALL) state_d = RUN;
            else                  idx_d   = idx_q + 1'b1;
          end
        end
        RUN: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = MRST;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    mmcm_rst_d = (state_d == MRST);
    ready_d    = (state_d == RUN);
  end

  // idx counts released stages, so the stage vector is a thermometer and cannot release out of order.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      assign rst_stage_d[gi] = (idx_d <= IDX_W'(gi));
    end
  endgenerate

  assign mmcm_rst        = mmcm_rst_q;
  assign rst_stage       = rst_stage_q;
  assign ready           = ready_q;
  assign lock_loss_count = lock_loss_q;
  assign timeout_count   = timeout_q;

endmodule
